// File: rtl/fv_bank_dispatcher.sv
// fv_bank_dispatcher: pops {addr,tag} requests, decodes the bank from the addr MSBs, waits on that bank's busy,
// then issues a one-cycle strobe to it. Define FV_DISPATCH_STATS_EN to add stall_cycles / issued_cnt counters.

module fv_bank_dispatcher #(
    parameter int NUM_BANKS  = 4,
    parameter int BANK_SEL_W = $clog2(NUM_BANKS),
    parameter int ADDR_W     = 8,
    parameter int TAG_W      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fifo_empty,
    input  logic                         fifo_rvalid,
    input  logic [ADDR_W-1:0]            fifo_addr,
    input  logic [TAG_W-1:0]             fifo_tag,
    output logic                         fifo_rinc,
    input  logic [NUM_BANKS-1:0]         bank_busy,
    output logic [NUM_BANKS-1:0]         bank_req_valid,
    output logic [ADDR_W-BANK_SEL_W-1:0] bank_req_addr,
    output logic [TAG_W-1:0]             bank_req_tag,
    output logic                         addr_err,
    output logic                         idle
`ifdef FV_DISPATCH_STATS_EN
    ,
    output logic [31:0]                  stall_cycles,
    output logic [31:0]                  issued_cnt
`endif
);
    localparam int BA_W = ADDR_W - BANK_SEL_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
    } req_t;

    typedef enum logic [1:0] {IDLE, FETCH, STALL, ISSUE} state_t;

    state_t                state, state_nxt;
    req_t                  hold;
    logic                  rinc_nxt, err_nxt, latch, issue;
    logic [BANK_SEL_W-1:0] fifo_bank, hold_bank, sel_bank;
    logic [NUM_BANKS-1:0]  lane_hit, lane_busy, issue_oh;
    logic                  sel_in_range, sel_is_busy;

    assign fifo_bank = fifo_addr[ADDR_W-1 -: BANK_SEL_W];
    assign hold_bank = hold.addr[ADDR_W-1 -: BANK_SEL_W];
    // FETCH judges the freshly returned word; STALL keeps re-checking the held one.
    assign sel_bank  = (state == FETCH) ? fifo_bank : hold_bank;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign lane_hit[b]  = (sel_bank == BANK_SEL_W'(b));
        assign lane_busy[b] = lane_hit[b] & bank_busy[b];
        assign issue_oh[b]  = issue && (hold_bank == BANK_SEL_W'(b));
    end

    // No lane matching means the decoded bank is beyond NUM_BANKS.
    assign sel_in_range = |lane_hit;
    assign sel_is_busy  = |lane_busy;
    assign idle         = (state == IDLE);

    always_comb begin
        state_nxt = state;
        rinc_nxt  = 1'b0;
        err_nxt   = 1'b0;
        latch     = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    rinc_nxt  = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                // Read data returns the cycle after the strobe, so the strobe cycle itself is skipped.
                if (!fifo_rinc) begin
                    if (!fifo_rvalid) begin
                        state_nxt = IDLE;
                    end else begin
                        latch = 1'b1;
                        if (!sel_in_range) begin
                            err_nxt   = 1'b1;
                            state_nxt = IDLE;
                        end else if (sel_is_busy) begin
                            state_nxt = STALL;
                        end else begin
                            state_nxt = ISSUE;
                        end
                    end
                end
            end
            STALL: begin
                if (!sel_is_busy) state_nxt = ISSUE;
            end
            ISSUE: begin
                issue = 1'b1;
                if (!fifo_empty) begin
                    rinc_nxt  = 1'b1;
                    state_nxt = FETCH;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            hold           <= '0;
            fifo_rinc      <= 1'b0;
            addr_err       <= 1'b0;
            bank_req_valid <= '0;
            bank_req_addr  <= '0;
            bank_req_tag   <= '0;
        end else begin
            state          <= state_nxt;
            fifo_rinc      <= rinc_nxt;
            addr_err       <= err_nxt;
            bank_req_valid <= issue_oh;
            if (latch) hold <= '{addr: fifo_addr, tag: fifo_tag};
            // Shared addr/tag only move on an issue so they hold between strobes.
            if (issue) begin
                bank_req_addr <= hold.addr[BA_W-1:0];
                bank_req_tag  <= hold.tag;
            end
        end
    end

`ifdef FV_DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= '0;
            issued_cnt   <= '0;
        end else begin
            if (state == STALL && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
            if (|bank_req_valid && issued_cnt != '1) issued_cnt <= issued_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fv_bank_dispatcher.sv
// Bench for fv_bank_dispatcher: a 4-bank and a 3-bank instance fed by queue-backed FIFO models,
// checked against the request stream pushed by the bench.
module tb_fv_bank_dispatcher;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       fifo_empty, fifo_rinc, addr_err, idle;
    logic       fifo_rvalid = 1'b0;
    logic [7:0] fifo_addr = '0;
    logic [3:0] fifo_tag = '0;
    logic [3:0] bank_busy = '0, bank_req_valid, bank_req_tag;
    logic [5:0] bank_req_addr;

    logic       fifo_empty3, fifo_rinc3, addr_err3, idle3;
    logic       fifo_rvalid3 = 1'b0;
    logic [7:0] fifo_addr3 = '0;
    logic [3:0] fifo_tag3 = '0;
    logic [2:0] bank_busy3 = '0, bank_req_valid3;
    logic [3:0] bank_req_tag3;
    logic [5:0] bank_req_addr3;
`ifdef FV_DISPATCH_STATS_EN
    logic [31:0] stall_cycles, issued_cnt, stall_cycles3, issued_cnt3;
`endif

    fv_bank_dispatcher #(.NUM_BANKS(4)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rvalid(fifo_rvalid),
        .fifo_addr(fifo_addr), .fifo_tag(fifo_tag), .fifo_rinc(fifo_rinc), .bank_busy(bank_busy),
        .bank_req_valid(bank_req_valid), .bank_req_addr(bank_req_addr), .bank_req_tag(bank_req_tag),
        .addr_err(addr_err), .idle(idle)
`ifdef FV_DISPATCH_STATS_EN
        , .stall_cycles(stall_cycles), .issued_cnt(issued_cnt)
`endif
    );

    fv_bank_dispatcher #(.NUM_BANKS(3)) dut3 (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty3), .fifo_rvalid(fifo_rvalid3),
        .fifo_addr(fifo_addr3), .fifo_tag(fifo_tag3), .fifo_rinc(fifo_rinc3), .bank_busy(bank_busy3),
        .bank_req_valid(bank_req_valid3), .bank_req_addr(bank_req_addr3), .bank_req_tag(bank_req_tag3),
        .addr_err(addr_err3), .idle(idle3)
`ifdef FV_DISPATCH_STATS_EN
        , .stall_cycles(stall_cycles3), .issued_cnt(issued_cnt3)
`endif
    );

    // FIFO models: entries pushed by the bench, popped on rinc, data returned the next cycle.
    logic [11:0] mem4 [0:255];
    logic [11:0] mem3 [0:255];
    int   wp4 = 0, rp4 = 0, wp3 = 0, rp3 = 0;
    logic race4 = 1'b0;
    assign fifo_empty  = (wp4 == rp4);
    assign fifo_empty3 = (wp3 == rp3);

    always @(posedge clk) begin
        fifo_rvalid <= 1'b0;
        if (fifo_rinc && !race4 && rp4 != wp4) begin
            fifo_rvalid <= 1'b1;
            {fifo_addr, fifo_tag} <= mem4[rp4];
            rp4 <= rp4 + 1;
        end
    end

    always @(posedge clk) begin
        fifo_rvalid3 <= 1'b0;
        if (fifo_rinc3 && rp3 != wp3) begin
            fifo_rvalid3 <= 1'b1;
            {fifo_addr3, fifo_tag3} <= mem3[rp3];
            rp3 <= rp3 + 1;
        end
    end

    // Event logs, written only by the monitors.
    typedef struct packed { int cyc; logic [3:0] v; logic [5:0] a; logic [3:0] t; } ev_t;
    ev_t  ev4[$], ev3[$];
    int   rq4[$], rq3[$], er3[$];
    int   cyc = 0, bad_oh = 0;
    logic [3:0] busy_hist [0:4095];

    always @(posedge clk) begin
        if (cyc < 4096) busy_hist[cyc] <= bank_busy;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (fifo_rinc)  rq4.push_back(cyc);
        if (fifo_rinc3) rq3.push_back(cyc);
        if (addr_err3)  er3.push_back(cyc);
        if (bank_req_valid != '0)  ev4.push_back('{cyc, bank_req_valid, bank_req_addr, bank_req_tag});
        if (bank_req_valid3 != '0) ev3.push_back('{cyc, {1'b0, bank_req_valid3}, bank_req_addr3, bank_req_tag3});
        if (!$onehot0(bank_req_valid) || !$onehot0(bank_req_valid3)) bad_oh <= bad_oh + 1;
    end

    int n_chk = 0, n_pass = 0;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push4(input logic [7:0] a, input logic [3:0] t);
        mem4[wp4] = {a, t};
        wp4 = wp4 + 1;
    endtask

    task automatic push3(input logic [7:0] a, input logic [3:0] t);
        mem3[wp3] = {a, t};
        wp3 = wp3 + 1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        n_chk++; if (fifo_rinc !== 1'b0) $display("FAIL reset_rinc: got %0b want 0", fifo_rinc); else n_pass++;
        n_chk++; if (bank_req_valid !== 4'b0) $display("FAIL reset_valid: got %b want 0000", bank_req_valid); else n_pass++;
        n_chk++; if (bank_req_addr !== 6'h0) $display("FAIL reset_addr: got %h want 00", bank_req_addr); else n_pass++;
        n_chk++; if (bank_req_tag !== 4'h0) $display("FAIL reset_tag: got %h want 0", bank_req_tag); else n_pass++;
        n_chk++; if (addr_err !== 1'b0) $display("FAIL reset_err: got %0b want 0", addr_err); else n_pass++;
        n_chk++; if (idle !== 1'b1 || idle3 !== 1'b1) $display("FAIL reset_idle: got %0b/%0b want 1/1", idle, idle3); else n_pass++;
`ifdef FV_DISPATCH_STATS_EN
        n_chk++; if (stall_cycles !== 32'd0 || issued_cnt !== 32'd0) $display("FAIL reset_stats: got %0d/%0d want 0/0", stall_cycles, issued_cnt); else n_pass++;
`endif
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        int r0, e0, t, c0;
        r0 = rq4.size(); e0 = ev4.size(); c0 = cyc;
        push4(8'hC5, 4'd3);
        for (int i = 0; i < 10 && rq4.size() == r0; i++) step();
        t = (rq4.size() > r0) ? rq4[r0] : -100;
        n_chk++; if (t != c0 + 1) $display("FAIL single_rinc_cycle: got %0d want %0d", t, c0 + 1); else n_pass++;
        for (int i = 0; i < 20 && ev4.size() == e0; i++) step();
        n_chk++;
        if (ev4.size() == e0) $display("FAIL single_issue: no bank_req_valid within budget");
        else begin
            n_pass++;
            n_chk++; if (ev4[e0].cyc != t + 3) $display("FAIL single_latency: got cycle %0d want %0d", ev4[e0].cyc, t + 3); else n_pass++;
            n_chk++; if (ev4[e0].v !== 4'b1000) $display("FAIL single_valid: got %b want 1000", ev4[e0].v); else n_pass++;
            n_chk++; if (ev4[e0].a !== 6'h05 || ev4[e0].t !== 4'd3) $display("FAIL single_payload: got %h/%h want 05/3", ev4[e0].a, ev4[e0].t); else n_pass++;
        end
        repeat (2) step();
        n_chk++; if (bank_req_valid !== 4'b0 || bank_req_addr !== 6'h05) $display("FAIL single_hold: got %b/%h want 0000/05", bank_req_valid, bank_req_addr); else n_pass++;
        n_chk++; if (idle !== 1'b1 || rq4.size() != r0 + 1) $display("FAIL single_idle: idle %0b pops %0d want 1/1", idle, rq4.size() - r0); else n_pass++;
    endtask

    task automatic test_stall();
        int r0, e0, f;
        reset = 1'b0; step(); reset = 1'b1; step();
        r0 = rq4.size(); e0 = ev4.size();
        bank_busy = 4'b1001;
        push4(8'hC5, 4'd7);
        for (int i = 0; i < 10 && rq4.size() == r0; i++) step();
        f = (rq4.size() > r0) ? rq4[r0] + 1 : cyc;
        // Held bank busy for 5 cycles from the data-return cycle; bank 0 stays busy throughout.
        while (cyc < f + 5) step();
        bank_busy = 4'b0001;
        for (int i = 0; i < 20 && ev4.size() == e0; i++) step();
        n_chk++;
        if (ev4.size() == e0) $display("FAIL stall_issue: no bank_req_valid within budget");
        else begin
            n_pass++;
            n_chk++; if (ev4[e0].cyc != f + 7) $display("FAIL stall_timing: got cycle %0d want %0d", ev4[e0].cyc, f + 7); else n_pass++;
            n_chk++; if (ev4[e0].v !== 4'b1000 || ev4[e0].t !== 4'd7) $display("FAIL stall_payload: got %b/%h want 1000/7", ev4[e0].v, ev4[e0].t); else n_pass++;
        end
        step();
`ifdef FV_DISPATCH_STATS_EN
        n_chk++; if (stall_cycles !== 32'd5) $display("FAIL stall_cycles: got %0d want 5", stall_cycles); else n_pass++;
        n_chk++; if (issued_cnt !== 32'd1) $display("FAIL issued_cnt: got %0d want 1", issued_cnt); else n_pass++;
`endif
        bank_busy = 4'b0000;
        step();
    endtask

    task automatic test_back_to_back();
        int r0, e0;
        logic [7:0] a [4];
        logic [3:0] t [4];
        r0 = rq4.size(); e0 = ev4.size();
        for (int i = 0; i < 4; i++) begin
            a[i] = {2'(i), 6'($urandom)};
            t[i] = 4'($urandom);
            push4(a[i], t[i]);
        end
        for (int i = 0; i < 60 && ev4.size() < e0 + 4; i++) step();
        n_chk++;
        if (ev4.size() < e0 + 4 || rq4.size() < r0 + 4) $display("FAIL b2b_count: got %0d issues %0d pops want 4/4", ev4.size() - e0, rq4.size() - r0);
        else begin
            n_pass++;
            for (int i = 0; i < 4; i++) begin
                logic [3:0] oh;
                oh = 4'b0001 << i;
                n_chk++; if (ev4[e0+i].v !== oh || ev4[e0+i].a !== a[i][5:0] || ev4[e0+i].t !== t[i])
                    $display("FAIL b2b_order[%0d]: got %b/%h/%h want %b/%h/%h", i, ev4[e0+i].v, ev4[e0+i].a, ev4[e0+i].t, oh, a[i][5:0], t[i]); else n_pass++;
                n_chk++; if (ev4[e0+i].cyc != rq4[r0+i] + 3) $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, ev4[e0+i].cyc, rq4[r0+i] + 3); else n_pass++;
                if (i > 0) begin
                    n_chk++; if (rq4[r0+i] != ev4[e0+i-1].cyc) $display("FAIL b2b_overlap[%0d]: rinc cycle %0d want %0d", i, rq4[r0+i], ev4[e0+i-1].cyc); else n_pass++;
                end
            end
        end
        step();
        n_chk++; if (idle !== 1'b1 || rq4.size() != r0 + 4) $display("FAIL b2b_idle: idle %0b pops %0d want 1/4", idle, rq4.size() - r0); else n_pass++;
    endtask

    task automatic test_addr_err();
        int r0, e0, x0;
        r0 = rq3.size(); e0 = ev3.size(); x0 = er3.size();
        push3(8'hE1, 4'd6);
        push3(8'h45, 4'd9);
        for (int i = 0; i < 30 && ev3.size() == e0; i++) step();
        repeat (4) step();
        n_chk++;
        if (er3.size() != x0 + 1 || ev3.size() != e0 + 1 || rq3.size() != r0 + 2)
            $display("FAIL err_counts: got err %0d issue %0d pops %0d want 1/1/2", er3.size() - x0, ev3.size() - e0, rq3.size() - r0);
        else begin
            n_pass++;
            n_chk++; if (er3[x0] != rq3[r0] + 2) $display("FAIL err_timing: got %0d want %0d", er3[x0], rq3[r0] + 2); else n_pass++;
            n_chk++; if (rq3[r0+1] != er3[x0] + 1) $display("FAIL err_next_pop: got %0d want %0d", rq3[r0+1], er3[x0] + 1); else n_pass++;
            n_chk++; if (ev3[e0].v !== 4'b0010 || ev3[e0].a !== 6'h05 || ev3[e0].t !== 4'd9)
                $display("FAIL err_next_issue: got %b/%h/%h want 0010/05/9", ev3[e0].v, ev3[e0].a, ev3[e0].t); else n_pass++;
        end
        n_chk++; if (idle3 !== 1'b1) $display("FAIL err_idle: got %0b want 1", idle3); else n_pass++;
    endtask

    task automatic test_reset_in_stall();
        int r0, e0, t;
        r0 = rq4.size(); e0 = ev4.size();
        bank_busy = 4'b0100;
        push4(8'h9A, 4'd5);
        for (int i = 0; i < 10 && rq4.size() == r0; i++) step();
        t = (rq4.size() > r0) ? rq4[r0] : cyc;
        while (cyc < t + 3) step();
        reset = 1'b0;
        step();
        n_chk++; if (fifo_rinc !== 1'b0 || bank_req_valid !== 4'b0 || addr_err !== 1'b0) $display("FAIL rst_stall_ctl: got %0b/%b/%0b want 0/0000/0", fifo_rinc, bank_req_valid, addr_err); else n_pass++;
        n_chk++; if (bank_req_addr !== 6'h0 || bank_req_tag !== 4'h0) $display("FAIL rst_stall_data: got %h/%h want 00/0", bank_req_addr, bank_req_tag); else n_pass++;
        n_chk++; if (idle !== 1'b1) $display("FAIL rst_stall_idle: got %0b want 1", idle); else n_pass++;
        reset = 1'b1;
        bank_busy = 4'b0000;
        repeat (10) step();
        n_chk++; if (ev4.size() != e0) $display("FAIL rst_stall_dropped: got %0d issues want 0", ev4.size() - e0); else n_pass++;
    endtask

    task automatic test_fifo_race();
        int r0, e0, t1;
        r0 = rq4.size(); e0 = ev4.size();
        race4 = 1'b1;
        push4(8'h47, 4'd2);
        for (int i = 0; i < 10 && rq4.size() == r0; i++) step();
        step();
        race4 = 1'b0;
        t1 = (rq4.size() > r0) ? rq4[r0] : -100;
        for (int i = 0; i < 20 && ev4.size() == e0; i++) step();
        repeat (3) step();
        n_chk++;
        if (rq4.size() != r0 + 2 || ev4.size() != e0 + 1) $display("FAIL race_counts: got pops %0d issues %0d want 2/1", rq4.size() - r0, ev4.size() - e0);
        else begin
            n_pass++;
            n_chk++; if (rq4[r0+1] != t1 + 3) $display("FAIL race_repop: got %0d want %0d", rq4[r0+1], t1 + 3); else n_pass++;
            n_chk++; if (ev4[e0].cyc != t1 + 6 || ev4[e0].v !== 4'b0010 || ev4[e0].a !== 6'h07 || ev4[e0].t !== 4'd2)
                $display("FAIL race_issue: got %0d/%b/%h/%h want %0d/0010/07/2", ev4[e0].cyc, ev4[e0].v, ev4[e0].a, ev4[e0].t, t1 + 6); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [11:0] exp_q[$];
        int e0, pushed;
        e0 = ev4.size(); pushed = 0;
        for (int c = 0; c < 3000 && ev4.size() < e0 + 30; c++) begin
            bank_busy = 4'($urandom);
            if (pushed < 30 && $urandom_range(0, 3) == 0) begin
                logic [11:0] w;
                w = 12'($urandom);
                push4(w[11:4], w[3:0]);
                exp_q.push_back(w);
                pushed++;
            end
            step();
        end
        bank_busy = 4'b0000;
        repeat (4) step();
        n_chk++;
        if (ev4.size() != e0 + 30) $display("FAIL rand_count: got %0d issues want 30", ev4.size() - e0);
        else begin
            n_pass++;
            for (int i = 0; i < 30; i++) begin
                logic [3:0] oh;
                int vc;
                oh = 4'b0001 << exp_q[i][11:10];
                vc = ev4[e0+i].cyc;
                n_chk++; if (ev4[e0+i].v !== oh || ev4[e0+i].a !== exp_q[i][9:4] || ev4[e0+i].t !== exp_q[i][3:0])
                    $display("FAIL rand_issue[%0d]: got %b/%h/%h want %b/%h/%h", i, ev4[e0+i].v, ev4[e0+i].a, ev4[e0+i].t, oh, exp_q[i][9:4], exp_q[i][3:0]); else n_pass++;
                n_chk++; if ((busy_hist[vc-2] & oh) !== 4'b0) $display("FAIL rand_busy[%0d]: bank busy %b at decision cycle %0d", i, busy_hist[vc-2], vc - 2); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_addr_err();
        test_reset_in_stall();
        test_fifo_race();
        test_random();
        n_chk++; if (bad_oh != 0) $display("FAIL onehot: got %0d multi-bit strobe cycles want 0", bad_oh); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
